// File: rtl/store_rmw_unit_if.sv
// Control-unit and data-memory signal bundle for store_rmw_unit.
// The slave modport is the unit's view and the master modport is the environment's view.
interface store_rmw_unit_if;
   logic        start;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] store_data;
   logic [63:0] mem_rdata;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_we;
   logic        busy;
   logic        done;
   logic        misalign;

   modport master (
      output start, funct3, addr, store_data, mem_rdata,
      input  mem_addr, mem_wdata, mem_we, busy, done, misalign
   );

   modport slave (
      input  start, funct3, addr, store_data, mem_rdata,
      output mem_addr, mem_wdata, mem_we, busy, done, misalign
   );
endinterface

// File: rtl/store_rmw_unit.sv
// Store unit for a 64-bit memory without byte enables: sb/sh/sw read-merge-write, sd writes directly.
// Define STORE_RMW_MISALIGN_TRAP_EN to reject misaligned sh/sw/sd with a misalign pulse.
module store_rmw_unit #(
   parameter int READ_LAT = 1
) (
   input logic             clk,
   input logic             reset,
   store_rmw_unit_if.slave bus
);
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_MISAL = 3'd4
   } state_t;

   localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);
`ifdef STORE_RMW_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   function automatic logic misaligned(input logic [1:0] f3, input logic [2:0] a);
      logic res;
      case (f3)
         2'd0:    res = 1'b0;
         2'd1:    res = a[0];
         2'd2:    res = (a[1:0] != 2'd0);
         default: res = (a != 3'd0);
      endcase
      return res;
   endfunction

   // Replicating the datum across the word lines it up with any naturally aligned lane group.
   function automatic logic [63:0] merge(input logic [1:0] f3, input logic [2:0] off,
                                         input logic [63:0] old, input logic [63:0] sd);
      logic [7:0]  lanes;
      logic [63:0] rep;
      logic [63:0] res;
      case (f3)
         2'd0: begin
            lanes = 8'b0000_0001 << off;
            rep   = {8{sd[7:0]}};
         end
         2'd1: begin
            lanes = 8'b0000_0011 << {off[2:1], 1'b0};
            rep   = {4{sd[15:0]}};
         end
         2'd2: begin
            lanes = 8'b0000_1111 << {off[2], 2'b00};
            rep   = {2{sd[31:0]}};
         end
         default: begin
            lanes = 8'hFF;
            rep   = sd;
         end
      endcase
      for (int k = 0; k < 8; k++) begin
         res[8*k +: 8] = lanes[k] ? rep[8*k +: 8] : old[8*k +: 8];
      end
      return res;
   endfunction

   state_t      state_r, state_s;
   logic        accept_s, trap_s;
   logic [1:0]  f3_r;
   logic [2:0]  off_r;
   logic [2:0]  cnt_r;
   logic [63:0] data_r;
   logic [63:0] mem_addr_r, mem_wdata_r;
   logic        mem_we_r, busy_r, done_r, misalign_r;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and request acceptance.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      trap_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start && !bus.funct3[2]) begin
               accept_s = 1'b1;
               trap_s   = TRAP_EN && misaligned(bus.funct3[1:0], bus.addr[2:0]);
               if (trap_s) begin
                  state_s = ST_MISAL;
               end else if (bus.funct3[1:0] == 2'd3) begin
                  state_s = ST_WRITE;
               end else begin
                  state_s = ST_READ;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ: begin
            if (cnt_r == LAT_LAST) begin
               state_s = ST_WRITE;
            end else begin
               state_s = ST_READ;
            end
         end
         ST_WRITE: state_s = ST_DONE;
         ST_DONE:  state_s = ST_IDLE;
         ST_MISAL: state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Request capture, read-latency counter, merge and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         f3_r        <= 2'd0;
         off_r       <= 3'd0;
         cnt_r       <= 3'd0;
         data_r      <= 64'd0;
         mem_addr_r  <= 64'd0;
         mem_wdata_r <= 64'd0;
         mem_we_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         misalign_r  <= 1'b0;
      end else begin
         mem_we_r   <= (state_s == ST_WRITE);
         busy_r     <= (state_s != ST_IDLE);
         done_r     <= (state_s == ST_DONE);
         misalign_r <= (state_s == ST_MISAL);
         if (accept_s && !trap_s) begin
            f3_r       <= bus.funct3[1:0];
            off_r      <= bus.addr[2:0];
            data_r     <= bus.store_data;
            mem_addr_r <= {bus.addr[63:3], 3'b000};
            cnt_r      <= 3'd0;
            if (bus.funct3[1:0] == 2'd3) begin
               mem_wdata_r <= bus.store_data;
            end
         end else if (state_r == ST_READ) begin
            // Read data is valid only on the last READ cycle, so merge straight from the bus.
            if (cnt_r == LAT_LAST) begin
               mem_wdata_r <= merge(f3_r, off_r, bus.mem_rdata, data_r);
            end else begin
               cnt_r <= cnt_r + 3'd1;
            end
         end
      end
   end

   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.misalign  = misalign_r;
endmodule

// File: tb/tb_store_rmw_unit.sv
// Scoreboard bench: two units (READ_LAT 1 and 3) share one request stream; a monitor
// pops expected write/done/misalign events per unit and compares cycle, address and data.
module tb_store_rmw_unit;
   typedef struct {
      int          kind;   // 0 write, 1 done, 2 misalign
      int          cyc;
      logic [63:0] addr;
      logic [63:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset;
   bit          mon_en = 1'b0;
   int          cyc = 0;
   int          vectors = 0;
   int          fails = 0;
   int          rc1 = 0;
   int          rc3 = 0;
   logic [63:0] rd_word, rd_addr;
   ev_t         q1[$];
   ev_t         q3[$];

   localparam logic [63:0] RD = 64'h1122_3344_5566_7788;

   store_rmw_unit_if b1();
   store_rmw_unit_if b3();

   assign b3.start      = b1.start;
   assign b3.funct3     = b1.funct3;
   assign b3.addr       = b1.addr;
   assign b3.store_data = b1.store_data;

   store_rmw_unit #(.READ_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   store_rmw_unit #(.READ_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: data is valid only READ_LAT cycles into a read of the expected doubleword.
   always @(negedge clk) begin
      if (b1.busy === 1'b1 && b1.mem_we !== 1'b1 && b1.done !== 1'b1 && b1.misalign !== 1'b1) rc1 = rc1 + 1;
      else rc1 = 0;
      if (b3.busy === 1'b1 && b3.mem_we !== 1'b1 && b3.done !== 1'b1 && b3.misalign !== 1'b1) rc3 = rc3 + 1;
      else rc3 = 0;
      b1.mem_rdata = (rc1 == 1 && b1.mem_addr == rd_addr) ? rd_word : 64'hBAD0_BAD0_BAD0_BAD0;
      b3.mem_rdata = (rc3 == 3 && b3.mem_addr == rd_addr) ? rd_word : 64'hBAD0_BAD0_BAD0_BAD0;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit tb_misal(input logic [2:0] f3, input logic [63:0] a);
      bit m;
      m = (f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0) || (f3 == 3'd3 && a[2:0] != 3'd0);
`ifndef STORE_RMW_MISALIGN_TRAP_EN
      m = 1'b0;
`endif
      return m;
   endfunction

   task automatic push(input int d, input int kind, input int c, input logic [63:0] a, input logic [63:0] w);
      ev_t e;
      e.kind = kind; e.cyc = c; e.addr = a; e.data = w;
      if (d == 0) q1.push_back(e);
      else q3.push_back(e);
   endtask

   task automatic mon(input int d, input logic we, input logic dn, input logic ms,
                      input logic [63:0] ma, input logic [63:0] wd);
      ev_t e;
      bit  have;
      int  kind;
      have = (d == 0) ? (q1.size() > 0) : (q3.size() > 0);
      if (have) e = (d == 0) ? q1[0] : q3[0];
      if (have && e.cyc < cyc) begin
         check($sformatf("missed_event_k%0d_lat%0d", e.kind, d * 2 + 1), 64'(cyc), 64'(e.cyc));
         if (d == 0) void'(q1.pop_front()); else void'(q3.pop_front());
         have = (d == 0) ? (q1.size() > 0) : (q3.size() > 0);
         if (have) e = (d == 0) ? q1[0] : q3[0];
      end
      if (we === 1'b1 || dn === 1'b1 || ms === 1'b1) begin
         kind = (we === 1'b1) ? 0 : (dn === 1'b1) ? 1 : 2;
         if (!have) begin
            vectors++;
            fails++;
            $display("FAIL unexpected_event_lat%0d: got kind %0d at cycle %0d, expected none", d * 2 + 1, kind, cyc);
         end else begin
            if (d == 0) void'(q1.pop_front()); else void'(q3.pop_front());
            check($sformatf("event_kind_lat%0d", d * 2 + 1), 64'(kind), 64'(e.kind));
            check($sformatf("event_cycle_lat%0d", d * 2 + 1), 64'(cyc), 64'(e.cyc));
            if (kind == 0) begin
               check($sformatf("mem_addr_lat%0d", d * 2 + 1), ma, e.addr);
               check($sformatf("mem_wdata_lat%0d", d * 2 + 1), wd, e.data);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, b1.mem_we, b1.done, b1.misalign, b1.mem_addr, b1.mem_wdata);
         mon(1, b3.mem_we, b3.done, b3.misalign, b3.mem_addr, b3.mem_wdata);
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_mem_addr1"}, b1.mem_addr, 64'd0);
      check({tag, "_mem_wdata1"}, b1.mem_wdata, 64'd0);
      check({tag, "_ctl1"}, {60'd0, b1.mem_we, b1.busy, b1.done, b1.misalign}, 64'd0);
      check({tag, "_mem_addr3"}, b3.mem_addr, 64'd0);
      check({tag, "_mem_wdata3"}, b3.mem_wdata, 64'd0);
      check({tag, "_ctl3"}, {60'd0, b3.mem_we, b3.busy, b3.done, b3.misalign}, 64'd0);
   endtask

   // Called at a negedge with both units idle; returns at a negedge with both idle again.
   task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] sdat,
                        input logic [63:0] rd, input logic [63:0] expw, input bit poke);
      bit          legal;
      bit          m;
      int          t;
      logic [63:0] da;
      legal = !f3[2];
      m     = legal && tb_misal(f3, a);
      da    = {a[63:3], 3'b000};
      b1.start = 1'b1; b1.funct3 = f3; b1.addr = a; b1.store_data = sdat;
      rd_word = rd; rd_addr = da;
      t = cyc + 1;
      if (m) begin
         push(0, 2, t, da, expw);
         push(1, 2, t, da, expw);
      end else if (legal && f3 == 3'd3) begin
         push(0, 0, t, da, expw); push(0, 1, t + 1, da, expw);
         push(1, 0, t, da, expw); push(1, 1, t + 1, da, expw);
      end else if (legal) begin
         push(0, 0, t + 1, da, expw); push(0, 1, t + 2, da, expw);
         push(1, 0, t + 3, da, expw); push(1, 1, t + 4, da, expw);
      end
      @(negedge clk);
      b1.start = 1'b0; b1.funct3 = ~f3; b1.addr = ~a; b1.store_data = ~sdat;
      check("busy_after_accept_lat1", {63'd0, b1.busy}, {63'd0, legal});
      check("busy_after_accept_lat3", {63'd0, b3.busy}, {63'd0, legal});
      if (poke) begin
         @(negedge clk);
         b1.start = 1'b1; b1.funct3 = 3'd0; b1.addr = 64'h50;
         @(negedge clk);
         b1.start = 1'b0;
      end
      for (int k = 0; k < 40 && (b1.busy || b3.busy); k++) @(negedge clk);
      check("return_to_idle", {62'd0, b1.busy, b3.busy}, 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      b1.start = 1'b0; b1.funct3 = 3'd0; b1.addr = 64'd0; b1.store_data = 64'd0;
      rd_word = 64'd0; rd_addr = 64'd0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      mon_en = 1'b1;

      issue(3'd0, 64'h13, 64'hAB,           RD,    64'h1122_3344_AB66_7788, 1'b0);
      issue(3'd0, 64'h07, 64'hFFFF_FF5A,    RD,    64'h5A22_3344_5566_7788, 1'b0);
      issue(3'd1, 64'h16, 64'hFFFF_BEEF,    RD,    64'hBEEF_3344_5566_7788, 1'b0);
      issue(3'd2, 64'h20, 64'hDEAD_BEEF,    64'd0, 64'h0000_0000_DEAD_BEEF, 1'b1);
      issue(3'd3, 64'h40, 64'h0123_4567_89AB_CDEF, RD, 64'h0123_4567_89AB_CDEF, 1'b0);
      issue(3'd2, 64'h24, 64'hCAFE_F00D,    RD,    64'hCAFE_F00D_5566_7788, 1'b0);
      issue(3'd1, 64'h08, 64'h1234,         64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_1234, 1'b0);
      issue(3'd4, 64'h30, 64'h55,           RD,    64'd0,                   1'b0);
      issue(3'd2, 64'h22, 64'hDEAD_BEEF,    RD,    64'h1122_3344_DEAD_BEEF, 1'b0);
      issue(3'd1, 64'h13, 64'hA5A5,         RD,    64'h1122_3344_A5A5_7788, 1'b0);
      issue(3'd3, 64'h45, 64'h0123_4567_89AB_CDEF, RD, 64'h0123_4567_89AB_CDEF, 1'b0);

      // Reset while both units are reading an sb: nothing may be written afterwards.
      b1.start = 1'b1; b1.funct3 = 3'd0; b1.addr = 64'h13; b1.store_data = 64'hAB;
      rd_word = RD; rd_addr = 64'h10;
      @(negedge clk);
      b1.start = 1'b0;
      check("busy_before_reset", {62'd0, b1.busy, b3.busy}, 64'd3);
      check("read_addr_lat3", b3.mem_addr, 64'h10);
      reset = 1'b1;
      @(negedge clk);
      check_zero("mid_reset");
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("idle_after_reset", {62'd0, b1.busy, b3.busy}, 64'd0);
      issue(3'd0, 64'h01, 64'h3C,           RD,    64'h1122_3344_5566_3C88, 1'b0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained_lat1", 64'(q1.size()), 64'd0);
      check("scoreboard_drained_lat3", 64'(q3.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
      $fatal(1, "timeout");
   end
endmodule
